// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_pkg
// Description : Shared mode codes, stage control payload and the generic
//               binary-to-Gray helper for the Gray/binary converter pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package gray_pkg;

    localparam int   MAX_WIDTH = 32;

    localparam logic MODE_B2G  = 1'b0;
    localparam logic MODE_G2B  = 1'b1;

    // Control half of a stage payload; the WIDTH-bit data word sits beside it
    // because its width is a per-instance parameter.
    typedef struct packed {
        logic valid;
        logic mode;
    } stage_ctl_t;

    // Callers zero-extend narrower words, so the top bit passes straight through.
    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_conv_stage.sv
`default_nettype none
// ============================================================================
// Module      : gray_conv_stage
// Description : One enabled pipeline register of the Gray/binary converter.
//               Resolves Gray->binary bits HI..LO, or (first stage only)
//               performs the complete binary->Gray conversion.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_conv_stage
    import gray_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LO    = 0,
    parameter int HI    = WIDTH - 1,
    parameter bit FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic             o_mode,
    output logic [WIDTH-1:0] o_data
);

    stage_ctl_t       r_ctl;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data;

    // Bits above HI are already binary in the partial word, so bit i+1 is the
    // running XOR for bit i. HI < LO leaves the stage as a plain delay.
    always_comb begin
        w_data = i_data;
        if (i_mode == MODE_B2G) begin
            if (FIRST) begin
                w_data = WIDTH'(bin2gray(MAX_WIDTH'(i_data)));
            end
        end else begin
            for (int i = WIDTH - 2; i >= 0; i--) begin
                if ((i >= LO) && (i <= HI)) begin
                    w_data[i] = w_data[i+1] ^ i_data[i];
                end
            end
        end
    end

    // Bubbles clear valid but leave data/mode untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctl  <= '0;
            r_data <= '0;
        end else if (i_en) begin
            r_ctl.valid <= i_valid;
            if (i_valid) begin
                r_ctl.mode <= i_mode;
                r_data     <= w_data;
            end
        end
    end

    assign o_valid = r_ctl.valid;
    assign o_mode  = r_ctl.mode;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/gray_bin_conv_pipe.sv
`default_nettype none
// ============================================================================
// Module      : gray_bin_conv_pipe
// Description : Pipelined binary<->Gray converter with per-word mode select
//               and a global-stall valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_bin_conv_pipe
    import gray_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode
);

    localparam int c_CHUNK = (WIDTH + STAGES - 1) / STAGES;

    logic             w_advance;
    logic [STAGES:0]  w_valid;
    logic [STAGES:0]  w_mode;
    logic [WIDTH-1:0] w_data [STAGES+1];

    // Whole pipe moves or holds together; no bubble squeezing.
    assign w_advance = out_ready | ~out_valid;
    assign in_ready  = w_advance;

    assign w_valid[0] = in_valid;
    assign w_mode[0]  = in_mode;
    assign w_data[0]  = in_data;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            localparam int c_HI = WIDTH - 1 - k * c_CHUNK;
            localparam int c_LO = (c_HI - c_CHUNK + 1 < 0) ? 0 : (c_HI - c_CHUNK + 1);

            gray_conv_stage #(
                .WIDTH (WIDTH),
                .LO    (c_LO),
                .HI    (c_HI),
                .FIRST (k == 0)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_en    (w_advance),
                .i_valid (w_valid[k]),
                .i_mode  (w_mode[k]),
                .i_data  (w_data[k]),
                .o_valid (w_valid[k+1]),
                .o_mode  (w_mode[k+1]),
                .o_data  (w_data[k+1])
            );
        end
    endgenerate

    assign out_valid = w_valid[STAGES];
    assign out_mode  = w_mode[STAGES];
    assign out_data  = w_data[STAGES];

endmodule
`default_nettype wire

// File: tb/tb_gray_bin_conv_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_bin_conv_pipe
// Description : Self-checking bench: 8-bit/3-stage main instance plus 4-bit
//               corner builds with 1, 2 and 4 stages.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_bin_conv_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // 8-bit, 3-stage instance
    logic       in_valid  = 1'b0;
    logic       in_mode   = 1'b0;
    logic [7:0] in_data   = 8'h00;
    logic       out_ready = 1'b1;
    logic       in_ready;
    logic       out_valid;
    logic       out_mode;
    logic [7:0] out_data;

    gray_bin_conv_pipe #(.WIDTH(8), .STAGES(3)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode)
    );

    // 4-bit corner builds sharing one input stream, consumer always ready
    logic       v4 = 1'b0;
    logic       m4 = 1'b0;
    logic [3:0] d4 = 4'h0;
    logic       ordy4 = 1'b1;
    logic [2:0] rdy4;
    logic [2:0] ov4;
    logic [2:0] om4;
    logic [3:0] od4 [3];
    int         lat4 [3] = '{1, 2, 4};

    generate
        for (genvar j = 0; j < 3; j++) begin : g_w4
            localparam int c_S = (j == 0) ? 1 : ((j == 1) ? 2 : 4);
            gray_bin_conv_pipe #(.WIDTH(4), .STAGES(c_S)) u_dut4 (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (v4),
                .in_ready  (rdy4[j]),
                .in_data   (d4),
                .in_mode   (m4),
                .out_valid (ov4[j]),
                .out_ready (ordy4),
                .out_data  (od4[j]),
                .out_mode  (om4[j])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_conv(input logic [7:0] d, input logic m);
        logic [7:0] r;
        if (!m) return d ^ (d >> 1);
        r[7] = d[7];
        for (int i = 6; i >= 0; i--) r[i] = r[i+1] ^ d[i];
        return r;
    endfunction

    // Scoreboard on the 8-bit instance, sampled mid-cycle
    logic [8:0] exp_q [$];
    logic [8:0] sb_exp;
    logic [7:0] rt_cap [$];
    int         rt_phase = 0;
    int         rt_idx   = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready)
                exp_q.push_back({in_mode, ref_conv(in_data, in_mode)});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra_word", 32'(out_valid), 32'd0);
                end else begin
                    sb_exp = exp_q.pop_front();
                    check("sb_word", {out_mode, out_data}, sb_exp);
                end
                if (rt_phase == 1) rt_cap.push_back(out_data);
                if (rt_phase == 2) begin
                    check("roundtrip", out_data, rt_idx);
                    rt_idx++;
                end
            end
        end
    end

    bit rand_rdy = 1'b0;
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a word and hold it until accepted; leaves in_valid high.
    task automatic send(input logic [7:0] d, input logic m);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        if (!acc) check("send_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        logic [3:0] vd [2];
        logic [3:0] ve [2];
        vd = '{4'b1011, 4'b1110};
        ve = '{4'b1110, 4'b1011};

        // Reset state
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_mode",  32'(out_mode),  32'd0);
        check("rst_w4_valid",  32'(ov4), 32'd0);
        check("rst_w4_ready",  32'(rdy4), 32'd7);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 4-bit directed vectors, latency per build
        for (int t = 0; t < 2; t++) begin
            v4 = 1'b1;
            d4 = vd[t];
            m4 = t[0];
            tick();
            v4 = 1'b0;
            for (int k = 0; k < 5; k++) begin
                if (k > 0) tick();
                for (int j = 0; j < 3; j++) begin
                    check($sformatf("w4_s%0d_valid_t%0d_k%0d", lat4[j], t, k),
                          32'(ov4[j]), 32'(k == lat4[j] - 1));
                    if (k == lat4[j] - 1) begin
                        check($sformatf("w4_s%0d_data_t%0d", lat4[j], t), 32'(od4[j]), 32'(ve[t]));
                        check($sformatf("w4_s%0d_mode_t%0d", lat4[j], t), 32'(om4[j]), 32'(t[0]));
                    end
                end
            end
        end

        // Back-to-back mixed modes on the 3-stage build
        in_valid = 1'b1; in_data = 8'hFF; in_mode = 1'b0;
        tick();
        in_data = 8'h80; in_mode = 1'b1;
        tick();
        in_valid = 1'b0;
        check("b2b_lat_valid", 32'(out_valid), 32'd0);
        tick();
        check("b2b_w0_valid", 32'(out_valid), 32'd1);
        check("b2b_w0_data",  32'(out_data),  32'h80);
        check("b2b_w0_mode",  32'(out_mode),  32'd0);
        tick();
        check("b2b_w1_valid", 32'(out_valid), 32'd1);
        check("b2b_w1_data",  32'(out_data),  32'hFF);
        check("b2b_w1_mode",  32'(out_mode),  32'd1);
        tick();
        check("b2b_after_valid", 32'(out_valid), 32'd0);

        // Exhaustive round trip: capture DUT Gray codes, feed them back
        rt_phase = 1;
        for (int v = 0; v < 256; v++) send(8'(v), 1'b0);
        in_valid = 1'b0;
        drain();
        check("rt_capture_count", rt_cap.size(), 256);
        rt_phase = 2;
        for (int v = 0; v < 256; v++) send(rt_cap[v], 1'b1);
        in_valid = 1'b0;
        drain();
        check("rt_checked_count", rt_idx, 256);
        rt_phase = 0;

        // Backpressure: 5A -> Gray 77 must hold while stalled
        send(8'h5A, 1'b0);
        send(8'h3C, 1'b1);
        send(8'hC3, 1'b0);
        out_ready = 1'b0;
        in_data   = 8'h99;
        in_mode   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data",  32'(out_data),  32'h77);
            check("stall_mode",  32'(out_mode),  32'd0);
            check("stall_ready", 32'(in_ready),  32'd0);
            tick();
        end
        out_ready = 1'b1;
        send(8'h99, 1'b1);
        in_valid = 1'b0;
        drain();

        // Random ready / valid traffic
        rand_rdy = 1'b1;
        for (int n = 0; n < 60; n++) begin
            send(8'($urandom), 1'($urandom_range(0, 1)));
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_rdy = 1'b0;
        tick();
        out_ready = 1'b1;
        drain();

        // Reset with two words in flight
        in_valid = 1'b1; in_data = 8'h11; in_mode = 1'b0;
        tick();
        in_data = 8'h22; in_mode = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready",  32'(in_ready),  32'd1);
        check("arst_out_data",  32'(out_data),  32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("post_rst_no_stale", 32'(out_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
